// File: rtl/sdram_burst_arb.sv
// sdram_burst_arb: two-requester (write / read) burst arbiter in front of an
// SDRAM controller core. One core burst is outstanding at a time; a one-cycle
// GAP follows every burst so the served requester can drop its request.
// Optional macro SDRAM_ARB_RD_PRIO_EN: read wins every tie instead of
// round-robin (keeps a display read stream from underflowing).
module sdram_burst_arb #(
  parameter int ADDR_BITS  = 24,
  parameter int BURST_BITS = 10,
  parameter int DATA_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write requester
  input  logic                  w_req,
  input  logic [BURST_BITS-1:0] w_len,
  input  logic [ADDR_BITS-1:0]  w_addr,
  output logic                  w_data_req,
  output logic                  w_finish,
  input  logic [DATA_BITS-1:0]  w_data,
  // read requester
  input  logic                  r_req,
  input  logic [BURST_BITS-1:0] r_len,
  input  logic [ADDR_BITS-1:0]  r_addr,
  output logic                  r_data_valid,
  output logic [DATA_BITS-1:0]  r_data,
  output logic                  r_finish,
  // core write port
  output logic                  wr_burst_req,
  output logic [BURST_BITS-1:0] wr_burst_len,
  output logic [ADDR_BITS-1:0]  wr_burst_addr,
  output logic [DATA_BITS-1:0]  wr_burst_data,
  input  logic                  wr_burst_data_req,
  input  logic                  wr_burst_finish,
  // core read port
  output logic                  rd_burst_req,
  output logic [BURST_BITS-1:0] rd_burst_len,
  output logic [ADDR_BITS-1:0]  rd_burst_addr,
  input  logic                  rd_burst_data_valid,
  input  logic [DATA_BITS-1:0]  rd_burst_data,
  input  logic                  rd_burst_finish,
  // status
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

  state_t state, state_nxt;
  logic   pick_wr, pick_rd;

`ifdef SDRAM_ARB_RD_PRIO_EN
  // Read always wins a tie; write only when read is not asking.
  always_comb begin
    pick_rd = r_req;
    pick_wr = w_req && !r_req;
  end
`else
  logic last_rd;

  // Round-robin tie break: on a tie, serve whoever was not served last.
  always_comb begin
    pick_wr = w_req && (!r_req || last_rd);
    pick_rd = r_req && !pick_wr;
  end

  // Remember the last owner; reset to read so write wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_rd <= 1'b1;
    else if (state == IDLE && (pick_wr || pick_rd))
      last_rd <= pick_rd;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. A burst ends on core finish, or immediately for a zero-length
  // grant (core req was never raised).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_wr)      state_nxt = WR;
            else if (pick_rd) state_nxt = RD;
      WR:   if (!wr_burst_req || wr_burst_finish) state_nxt = GAP;
      RD:   if (!rd_burst_req || rd_burst_finish) state_nxt = GAP;
      GAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Core-side request/len/addr capture and requester finish pulses. Len/addr
  // are captured at grant only, so requester inputs can move freely mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      rd_burst_addr <= '0;
      w_finish      <= 1'b0;
      r_finish      <= 1'b0;
    end else begin
      w_finish <= 1'b0;
      r_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_wr) begin
            wr_burst_len  <= w_len;
            wr_burst_addr <= w_addr;
            wr_burst_req  <= (w_len != '0);
          end else if (pick_rd) begin
            rd_burst_len  <= r_len;
            rd_burst_addr <= r_addr;
            rd_burst_req  <= (r_len != '0);
          end
        end
        WR: if (!wr_burst_req || wr_burst_finish) begin
          wr_burst_req <= 1'b0;
          w_finish     <= 1'b1;
        end
        RD: if (!rd_burst_req || rd_burst_finish) begin
          rd_burst_req <= 1'b0;
          r_finish     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data strobes pass through only for the current owner.
  assign w_data_req    = wr_burst_data_req && (state == WR);
  assign wr_burst_data = w_data;
  assign r_data        = rd_burst_data;
  assign r_data_valid  = rd_burst_data_valid && (state == RD);
  assign grant         = {state == RD, state == WR};
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sdram_burst_arb.sv
// Bench for sdram_burst_arb: behavioural SDRAM core model, a grant / read-data
// scoreboard monitor, and one task per scenario.
module tb_sdram_burst_arb;
  localparam int AB = 24, BB = 10, DB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          w_req, w_data_req, w_finish;
  logic [BB-1:0] w_len;
  logic [AB-1:0] w_addr;
  logic [DB-1:0] w_data;
  logic          r_req, r_data_valid, r_finish;
  logic [BB-1:0] r_len;
  logic [AB-1:0] r_addr;
  logic [DB-1:0] r_data;
  logic          wr_burst_req, wr_burst_data_req, wr_burst_finish;
  logic [BB-1:0] wr_burst_len;
  logic [AB-1:0] wr_burst_addr;
  logic [DB-1:0] wr_burst_data;
  logic          rd_burst_req, rd_burst_data_valid, rd_burst_finish;
  logic [BB-1:0] rd_burst_len;
  logic [AB-1:0] rd_burst_addr;
  logic [DB-1:0] rd_burst_data;
  logic [1:0]    grant;
  logic          busy;

  // core model drive + spurious injection
  logic          core_wdreq, core_wfin, core_rvalid, core_rfin;
  logic [DB-1:0] core_rdata;
  logic          spur_rvalid, spur_rfin;
  assign wr_burst_data_req   = core_wdreq;
  assign wr_burst_finish     = core_wfin;
  assign rd_burst_data_valid = core_rvalid | spur_rvalid;
  assign rd_burst_finish     = core_rfin | spur_rfin;
  assign rd_burst_data       = core_rdata;

  logic [1:0]    grant_q[$];
  logic [DB-1:0] rdata_q[$];
  int n_checks, n_pass;

  sdram_burst_arb #(.ADDR_BITS(AB), .BURST_BITS(BB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_req(w_req), .w_len(w_len), .w_addr(w_addr), .w_data_req(w_data_req),
    .w_finish(w_finish), .w_data(w_data),
    .r_req(r_req), .r_len(r_len), .r_addr(r_addr), .r_data_valid(r_data_valid),
    .r_data(r_data), .r_finish(r_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
    .rd_burst_addr(rd_burst_addr), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
    .grant(grant), .busy(busy)
  );

  // SDRAM core model: len data strobes starting the cycle req is seen, then finish.
  initial begin
    int wcnt, rcnt;
    bit wact, ract;
    wcnt = 0; rcnt = 0; wact = 0; ract = 0;
    core_wdreq = 0; core_wfin = 0; core_rvalid = 0; core_rfin = 0; core_rdata = '0;
    forever begin
      @(posedge clk); #1;
      core_wdreq = 0; core_wfin = 0; core_rvalid = 0; core_rfin = 0;
      if (!rst_n) begin
        wact = 0; ract = 0;
      end else begin
        if (wr_burst_req && !wact) begin wact = 1; wcnt = 0; end
        if (wact) begin
          if (wcnt < int'(wr_burst_len)) begin core_wdreq = 1; wcnt++; end
          else begin core_wfin = 1; wact = 0; end
        end
        if (rd_burst_req && !ract) begin ract = 1; rcnt = 0; end
        if (ract) begin
          if (rcnt < int'(rd_burst_len)) begin
            core_rvalid = 1;
            core_rdata  = rd_burst_addr[15:0] + 16'(rcnt * 7);
            rdata_q.push_back(core_rdata);
            rcnt++;
          end else begin core_rfin = 1; ract = 0; end
        end
      end
    end
  end

  // Scoreboard monitor: grant order and read data.
  initial begin
    logic [1:0]    pg, eg;
    logic [DB-1:0] ed;
    pg = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) pg = 2'b00;
      else begin
        if (grant != 2'b00 && pg == 2'b00) begin
          n_checks++;
          if (grant_q.size() == 0) $display("FAIL grant_order: got %b, none expected", grant);
          else begin
            eg = grant_q.pop_front();
            if (grant !== eg) $display("FAIL grant_order: got %b want %b", grant, eg);
            else n_pass++;
          end
        end
        pg = grant;
        if (r_data_valid) begin
          n_checks++;
          if (rdata_q.size() == 0) $display("FAIL r_data: unexpected strobe data %h", r_data);
          else begin
            ed = rdata_q.pop_front();
            if (r_data !== ed) $display("FAIL r_data: got %h want %h", r_data, ed);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; w_req = 0; r_req = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    grant_q.delete(); rdata_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 0; w_req = 1; r_req = 1; w_len = 4; r_len = 4;
    w_addr = 'h12; r_addr = 'h34;
    repeat (2) @(negedge clk);
    n_checks++; if ({wr_burst_req, rd_burst_req} !== 2'b00)
      $display("FAIL rst_core_req: got %b want 00", {wr_burst_req, rd_burst_req}); else n_pass++;
    n_checks++; if ({w_finish, r_finish} !== 2'b00)
      $display("FAIL rst_finish: got %b want 00", {w_finish, r_finish}); else n_pass++;
    n_checks++; if ({grant, busy} !== 3'b000)
      $display("FAIL rst_grant_busy: got %b want 000", {grant, busy}); else n_pass++;
    n_checks++; if ({wr_burst_len, wr_burst_addr, rd_burst_len, rd_burst_addr} !== '0)
      $display("FAIL rst_len_addr: got %h/%h %h/%h want 0", wr_burst_len, wr_burst_addr, rd_burst_len, rd_burst_addr);
    else n_pass++;
    tick(); w_req = 0; r_req = 0; rst_n = 1;
  endtask

  // Single write burst len 8 at 0x100; requester drops req right after grant.
  task automatic test_single_write();
    int strobes, fins;
    bit done;
    strobes = 0; fins = 0; done = 0;
    tick(); w_req = 1; w_len = 8; w_addr = 'h100; grant_q.push_back(2'b01);
    @(negedge clk);
    n_checks++; if (wr_burst_req !== 1'b0) $display("FAIL wr_req_early: got 1 want 0"); else n_pass++;
    tick(); w_req = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i != 0) tick();
      w_data = 16'(i * 3 + 1);
      @(negedge clk);
      if (i == 0) begin
        n_checks++; if (wr_burst_req !== 1'b1) $display("FAIL wr_req_latency: got %b want 1", wr_burst_req); else n_pass++;
        n_checks++; if (wr_burst_addr !== 24'h100) $display("FAIL wr_addr: got %h want 100", wr_burst_addr); else n_pass++;
        n_checks++; if (wr_burst_len !== 10'd8) $display("FAIL wr_len: got %0d want 8", wr_burst_len); else n_pass++;
      end
      if (w_data_req) begin
        strobes++;
        n_checks++; if (wr_burst_data !== w_data)
          $display("FAIL wr_data_pass: got %h want %h", wr_burst_data, w_data); else n_pass++;
      end
      if (fins > 0 && !w_finish) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL wr_gap_len: busy %b want 0", busy); else n_pass++;
        done = 1;
      end
      if (w_finish) begin
        fins++;
        n_checks++; if ({grant, busy, wr_burst_req} !== 4'b0010)
          $display("FAIL wr_gap_state: got %b want 0010", {grant, busy, wr_burst_req}); else n_pass++;
      end
    end
    n_checks++; if (strobes != 8) $display("FAIL wr_strobes: got %0d want 8", strobes); else n_pass++;
    n_checks++; if (fins != 1 || !done) $display("FAIL wr_finish: got %0d pulses done=%0d want 1", fins, done); else n_pass++;
  endtask

  // Zero-length read: finish two cycles after request, core never asked.
  task automatic test_zero_len();
    bit rdreq_seen;
    rdreq_seen = 0;
    tick(); r_req = 1; r_len = 0; r_addr = 'h55; grant_q.push_back(2'b10);
    @(negedge clk); rdreq_seen |= rd_burst_req;
    tick(); r_req = 0;
    @(negedge clk); rdreq_seen |= rd_burst_req;
    n_checks++; if ({grant, r_finish} !== 3'b100)
      $display("FAIL zl_cycle1: grant/fin %b want 100", {grant, r_finish}); else n_pass++;
    tick(); @(negedge clk); rdreq_seen |= rd_burst_req;
    n_checks++; if ({r_finish, busy, grant} !== 4'b1100)
      $display("FAIL zl_finish: fin/busy/grant %b want 1100", {r_finish, busy, grant}); else n_pass++;
    tick(); @(negedge clk); rdreq_seen |= rd_burst_req;
    n_checks++; if ({r_finish, busy} !== 2'b00)
      $display("FAIL zl_idle: fin/busy %b want 00", {r_finish, busy}); else n_pass++;
    n_checks++; if (rdreq_seen !== 1'b0) $display("FAIL zl_core_req: got 1 want 0"); else n_pass++;
  endtask

  // Requester inputs move and read-port noise arrives during a write burst.
  task automatic test_isolation();
    int strobes, fins, bad;
    bit done;
    strobes = 0; fins = 0; bad = 0; done = 0;
    tick(); w_req = 1; w_len = 6; w_addr = 'h200; grant_q.push_back(2'b01);
    tick(); w_req = 0; w_len = 1; w_addr = 'h3FF; spur_rvalid = 1; spur_rfin = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i != 0) tick();
      if (i == 4) begin spur_rvalid = 0; spur_rfin = 0; end
      @(negedge clk);
      if (grant == 2'b01 && (wr_burst_addr !== 24'h200 || wr_burst_len !== 10'd6)) begin
        bad++; $display("FAIL iso_hold: addr %h len %0d want 200/6", wr_burst_addr, wr_burst_len);
      end
      if (r_data_valid || r_finish) begin
        bad++; $display("FAIL iso_read: r_data_valid %b r_finish %b want 0", r_data_valid, r_finish);
      end
      if (w_data_req) strobes++;
      if (fins > 0 && !w_finish) done = 1;
      if (w_finish) fins++;
    end
    n_checks++; if (bad != 0) $display("FAIL iso_cycles: %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (strobes != 6) $display("FAIL iso_strobes: got %0d want 6", strobes); else n_pass++;
    n_checks++; if (fins != 1 || !done) $display("FAIL iso_finish: got %0d done=%0d want 1", fins, done); else n_pass++;
  endtask

  // Both requesters held from reset: four grants, one GAP cycle between each.
  task automatic test_back_to_back();
    int ngr, gapc, badgap;
    logic [1:0] pg;
    bit done;
    ngr = 0; gapc = 0; badgap = 0; done = 0; pg = 2'b00;
    do_reset();
`ifdef SDRAM_ARB_RD_PRIO_EN
    repeat (4) grant_q.push_back(2'b10);
`else
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
`endif
    w_req = 1; w_len = 3; w_addr = 'h700; r_req = 1; r_len = 2; r_addr = 'h900;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (ngr == 4) begin w_req = 0; r_req = 0; end
      @(negedge clk);
      if (grant != 2'b00 && pg == 2'b00) begin
        ngr++;
        if (ngr > 1 && gapc != 1) begin
          badgap++; $display("FAIL b2b_gap: %0d gap cycles want 1", gapc);
        end
        gapc = 0;
      end
      if (grant == 2'b00 && busy) gapc++;
      pg = grant;
      if (ngr >= 4 && !busy && !w_req) done = 1;
    end
    n_checks++; if (ngr != 4) $display("FAIL b2b_grants: got %0d want 4", ngr); else n_pass++;
    n_checks++; if (badgap != 0 || !done) $display("FAIL b2b_gaps: bad %0d done=%0d", badgap, done); else n_pass++;
  endtask

  // Reset four words into a 16-word read: outputs clear at once, no finish,
  // and a following write is served normally.
  task automatic test_reset_mid_burst();
    int words, fins, strobes;
    bit done;
    words = 0; fins = 0; strobes = 0; done = 0;
    tick(); r_req = 1; r_len = 16; r_addr = 'h400; grant_q.push_back(2'b10);
    for (int i = 0; i < 30 && words < 4; i++) begin
      tick(); @(negedge clk);
      if (r_data_valid) words++;
    end
    n_checks++; if (words != 4) $display("FAIL rmb_words: got %0d want 4", words); else n_pass++;
    #1; rst_n = 0; r_req = 0; #1;
    n_checks++; if ({rd_burst_req, grant, busy, r_data_valid} !== 5'b0)
      $display("FAIL rmb_async: got %b want 00000", {rd_burst_req, grant, busy, r_data_valid}); else n_pass++;
    n_checks++; if ({rd_burst_len, rd_burst_addr} !== '0)
      $display("FAIL rmb_len_addr: got %h/%h want 0", rd_burst_len, rd_burst_addr); else n_pass++;
    rdata_q.delete(); grant_q.delete();
    repeat (2) begin @(negedge clk); fins += int'(r_finish); end
    tick(); rst_n = 1;
    repeat (3) begin @(negedge clk); fins += int'(r_finish); tick(); end
    n_checks++; if (fins != 0) $display("FAIL rmb_no_finish: got %0d pulses want 0", fins); else n_pass++;
    w_req = 1; w_len = 2; w_addr = 'h10; grant_q.push_back(2'b01);
    tick(); w_req = 0;
    fins = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i != 0) tick();
      @(negedge clk);
      if (i == 0) begin
        n_checks++; if ({wr_burst_req, wr_burst_addr} !== {1'b1, 24'h10})
          $display("FAIL rmb_wr_start: req/addr %b/%h want 1/10", wr_burst_req, wr_burst_addr); else n_pass++;
      end
      if (w_data_req) strobes++;
      if (fins > 0 && !w_finish) done = 1;
      if (w_finish) fins++;
    end
    n_checks++; if (strobes != 2 || fins != 1 || !done)
      $display("FAIL rmb_wr_burst: strobes %0d fins %0d want 2/1", strobes, fins); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 0; w_req = 0; r_req = 0; w_len = '0; r_len = '0;
    w_addr = '0; r_addr = '0; w_data = '0; spur_rvalid = 0; spur_rfin = 0;
    test_reset();
    test_single_write();
    test_zero_len();
    test_isolation();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (3) tick();
    n_checks++; if (grant_q.size() != 0 || rdata_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d grants %0d words left", grant_q.size(), rdata_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sdram_burst_arb.md
SDRAM_BURST_ARB -- requirements
Module: sdram_burst_arb

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24, burst address width.
REQ-002 SHALL have parameter BURST_BITS, default 10, burst length width.
REQ-003 SHALL have parameter DATA_BITS, default 16, data width.
REQ-004 SHALL have port clk  in  1  controller/memory clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports w_req / w_len / w_addr  in  1/BURST_BITS/ADDR_BITS  write requester burst request, length in words, start address.
REQ-007 SHALL have ports w_data_req / w_finish  out  1/1  write data strobe (data due next cycle) and burst-done pulse to write requester.
REQ-008 SHALL have port w_data  in  DATA_BITS  write requester data.
REQ-009 SHALL have ports r_req / r_len / r_addr  in  1/BURST_BITS/ADDR_BITS  read requester burst request, length, address.
REQ-010 SHALL have ports r_data_valid / r_data / r_finish  out  1/DATA_BITS/1  read data strobe, data, burst-done pulse.
REQ-011 SHALL have ports wr_burst_req / wr_burst_len / wr_burst_addr / wr_burst_data  out  1/BURST_BITS/ADDR_BITS/DATA_BITS  to SDRAM core write port.
REQ-012 SHALL have ports wr_burst_data_req / wr_burst_finish  in  1/1  from SDRAM core write port.
REQ-013 SHALL have ports rd_burst_req / rd_burst_len / rd_burst_addr  out  1/BURST_BITS/ADDR_BITS  to SDRAM core read port.
REQ-014 SHALL have ports rd_burst_data_valid / rd_burst_data / rd_burst_finish  in  1/DATA_BITS/1  from SDRAM core read port.
REQ-015 SHALL have ports grant / busy  out  2/1  current owner (01 write, 10 read, 00 none) and state != IDLE.

Function
REQ-016 SHALL implement FSM IDLE, WR, RD, GAP; only one core burst outstanding at any time.
REQ-017 IDLE: sample w_req/r_req; if only one asserted, grant it; if both, arbitrate per REQ-018 (or REQ-033).
REQ-018 Default arbitration SHALL be round-robin: on simultaneous requests grant the requester not granted last; last_grant updates on every grant.
REQ-019 On grant SHALL register len and addr into core-side outputs and assert wr_burst_req or rd_burst_req in the first cycle of WR/RD (one-cycle latency from sampled request).
REQ-020 Core-side req SHALL stay high until the matching *_burst_finish is sampled, then deassert on the next edge.
REQ-021 Core-side len/addr SHALL be held stable for the whole burst regardless of requester input changes.
REQ-022 w_data_req = wr_burst_data_req AND state==WR; wr_burst_data = w_data (combinational passthrough).
REQ-023 r_data = rd_burst_data; r_data_valid = rd_burst_data_valid AND state==RD (combinational).
REQ-024 w_finish/r_finish SHALL be one-cycle pulses mirroring the core finish while in WR/RD; then FSM -> GAP.
REQ-025 GAP SHALL last exactly one cycle so the served requester can drop its req; then -> IDLE; requests ignored in GAP.
REQ-026 Zero length (len==0) SHALL NOT reach the core: arbiter pulses the requester's finish in the cycle after grant and goes to GAP.
REQ-027 Core strobes/finish arriving for the non-granted port SHALL be ignored (no output, no state change).
REQ-028 Requester deasserting req mid-burst SHALL NOT abort the burst; burst completes at core finish.

Reset
REQ-029 rst_n low SHALL asynchronously force FSM=IDLE, last_grant=read (write wins first tie), all registered outputs 0, grant=00, busy=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no finish pulse; SDRAM core shares rst_n and resets with it.

Configuration
REQ-031 Macro SDRAM_ARB_RD_PRIO_EN SHALL select tie-break policy.
REQ-032 Without SDRAM_ARB_RD_PRIO_EN: round-robin per REQ-018.
REQ-033 With SDRAM_ARB_RD_PRIO_EN: read always wins simultaneous requests (display underflow avoidance); last_grant unused; all other behaviour identical.

Verification
REQ-034 Reset, w_req=1 len=8 addr=0x100 -> wr_burst_req=1 next cycle, wr_burst_addr=0x100, 8 w_data_req strobes, w_finish one pulse, GAP, IDLE.
REQ-035 w_req and r_req both 1 from reset, held (round-robin build) -> grants write, read, write, read, each separated by one GAP cycle.
REQ-036 Same stimulus with SDRAM_ARB_RD_PRIO_EN -> read granted first and every time r_req is high at IDLE.
REQ-037 r_req len=0 -> r_finish pulse 2 cycles after request, rd_burst_req never asserted.
REQ-038 During write burst, change w_addr and pulse spurious rd_burst_data_valid -> wr_burst_addr unchanged, r_data_valid stays 0.
REQ-039 Assert rst_n=0 mid read burst (4 of 16 words) -> outputs 0 immediately, no r_finish; after release new w_req is served normally.
